// File: rtl/cpu_pipe_pkg.sv
// Shared constants and state encoding for the MCS8 pipeline sequencing controller.
package cpu_pipe_pkg;

  localparam int DEF_REG_W     = 3;
  localparam int DEF_DRAIN_CYC = 3;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/cpu_hazard_det.sv
// Load-use hazard detector: a D operand that depends on a load still in E or M
// cannot be forwarded, because only W supplies the loaded value.
module cpu_hazard_det
  import cpu_pipe_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_src_a,
  input  logic             d_src_a_use,
  input  logic [REG_W-1:0] d_src_b,
  input  logic             d_src_b_use,
  input  logic             e_valid,
  input  logic [REG_W-1:0] e_dst,
  input  logic             e_load,
  input  logic             m_valid,
  input  logic [REG_W-1:0] m_dst,
  input  logic             m_load,
  output logic             lu
);

  logic match_e;
  logic match_m;
  logic hit_e;
  logic hit_m;

  assign match_e = (d_src_a_use && (e_dst == d_src_a)) || (d_src_b_use && (e_dst == d_src_b));
  assign match_m = (d_src_a_use && (m_dst == d_src_a)) || (d_src_b_use && (m_dst == d_src_b));
  assign hit_e   = e_valid && e_load && match_e;
  assign hit_m   = m_valid && m_load && match_m;
  assign lu      = d_valid && (hit_e || hit_m);

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline sequencing controller: stall/bubble/freeze arbitration plus HALT drain
// and interrupt wake. Define CPU_PIPE_CTRL_PERF_EN to add saturating perf counters.
module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_W     = DEF_REG_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
`ifdef CPU_PIPE_CTRL_PERF_EN
  , parameter int CNT_W   = DEF_CNT_W
`endif
) (
  input  logic             CLK_I,
  input  logic             RST_N_I,
  input  logic             D_VALID_I,
  input  logic [REG_W-1:0] D_SRC_A_I,
  input  logic             D_SRC_A_USE_I,
  input  logic [REG_W-1:0] D_SRC_B_I,
  input  logic             D_SRC_B_USE_I,
  input  logic             D_HALT_I,
  input  logic             E_VALID_I,
  input  logic [REG_W-1:0] E_DST_I,
  input  logic             E_DSTR_CS_M_I,
  input  logic             M_VALID_I,
  input  logic [REG_W-1:0] M_DST_I,
  input  logic             M_DSTR_CS_M_I,
  input  logic             E_REDIRECT_I,
  input  logic             MEM_READY_I,
  input  logic             INT_REQ_I,
  output logic             F_STALL_O,
  output logic             D_STALL_O,
  output logic             D_BUBBLE_O,
  output logic             E_BUBBLE_O,
  output logic             PIPE_FREEZE_O,
  output logic             HALTED_O,
  output logic             INT_ACK_O
`ifdef CPU_PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] PERF_LU_CNT_O
  , output logic [CNT_W-1:0] PERF_FLUSH_CNT_O
  , output logic [CNT_W-1:0] PERF_FREEZE_CNT_O
`endif
);

  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic [DCNT_W-1:0] drain_cnt;
  logic [DCNT_W-1:0] drain_cnt_nxt;
  logic              ack_nxt;
  logic              lu;

  cpu_hazard_det #(.REG_W(REG_W)) u_hazard (
    .d_valid     (D_VALID_I),
    .d_src_a     (D_SRC_A_I),
    .d_src_a_use (D_SRC_A_USE_I),
    .d_src_b     (D_SRC_B_I),
    .d_src_b_use (D_SRC_B_USE_I),
    .e_valid     (E_VALID_I),
    .e_dst       (E_DST_I),
    .e_load      (E_DSTR_CS_M_I),
    .m_valid     (M_VALID_I),
    .m_dst       (M_DST_I),
    .m_load      (M_DSTR_CS_M_I),
    .lu          (lu)
  );

  // A redirect during DRAIN comes from an older instruction, so the halt is abandoned
  // and F must be free to fetch the new target.
  always_comb begin
    F_STALL_O     = 1'b0;
    D_STALL_O     = 1'b0;
    D_BUBBLE_O    = 1'b0;
    E_BUBBLE_O    = 1'b0;
    PIPE_FREEZE_O = 1'b0;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    ack_nxt       = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (!MEM_READY_I) begin
          PIPE_FREEZE_O = 1'b1;
          F_STALL_O     = 1'b1;
          D_STALL_O     = 1'b1;
        end else if (E_REDIRECT_I) begin
          D_BUBBLE_O = 1'b1;
          E_BUBBLE_O = 1'b1;
        end else if (lu) begin
          F_STALL_O  = 1'b1;
          D_STALL_O  = 1'b1;
          E_BUBBLE_O = 1'b1;
        end else if (D_VALID_I && D_HALT_I) begin
          F_STALL_O     = 1'b1;
          D_BUBBLE_O    = 1'b1;
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DCNT_W'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        if (!MEM_READY_I) begin
          F_STALL_O     = 1'b1;
          D_BUBBLE_O    = 1'b1;
          PIPE_FREEZE_O = 1'b1;
        end else if (E_REDIRECT_I) begin
          D_BUBBLE_O = 1'b1;
          E_BUBBLE_O = 1'b1;
          state_nxt  = ST_RUN;
        end else begin
          F_STALL_O  = 1'b1;
          D_BUBBLE_O = 1'b1;
          if (drain_cnt == '0) begin
            state_nxt = ST_HALTED;
          end else begin
            drain_cnt_nxt = drain_cnt - 1'b1;
          end
        end
      end
      ST_HALTED: begin
        F_STALL_O  = 1'b1;
        D_BUBBLE_O = 1'b1;
        if (INT_REQ_I) begin
          state_nxt = ST_RUN;
          ack_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      HALTED_O  <= 1'b0;
      INT_ACK_O <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      HALTED_O  <= (state_nxt == ST_HALTED);
      INT_ACK_O <= ack_nxt;
    end
  end

`ifdef CPU_PIPE_CTRL_PERF_EN
  logic lu_run;
  assign lu_run = (state == ST_RUN) && MEM_READY_I && !E_REDIRECT_I && lu;

  // Counters stick at all-ones so a long run never wraps into a misleading small value.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      PERF_LU_CNT_O     <= '0;
      PERF_FLUSH_CNT_O  <= '0;
      PERF_FREEZE_CNT_O <= '0;
    end else begin
      if (lu_run && !(&PERF_LU_CNT_O))
        PERF_LU_CNT_O <= PERF_LU_CNT_O + 1'b1;
      if (E_REDIRECT_I && !(&PERF_FLUSH_CNT_O))
        PERF_FLUSH_CNT_O <= PERF_FLUSH_CNT_O + 1'b1;
      if (!MEM_READY_I && !(&PERF_FREEZE_CNT_O))
        PERF_FREEZE_CNT_O <= PERF_FREEZE_CNT_O + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Self-checking bench for cpu_pipe_ctrl: directed scenarios plus randomized traffic
// against a behavioural model. Output vector order: {F_STALL, D_STALL, D_BUBBLE, E_BUBBLE, FREEZE, HALTED, INT_ACK}.
module tb_cpu_pipe_ctrl;

  localparam int DRAIN_CYC = 3;
  localparam int CW        = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       d_valid, d_use_a, d_use_b, d_halt;
  logic [2:0] d_src_a, d_src_b, e_dst, m_dst;
  logic       e_valid, e_load, m_valid, m_load;
  logic       redir, mem_ready, int_req;
  logic       f_stall, d_stall, d_bubble, e_bubble, freeze, halted, int_ack;
  logic [6:0] obs;
  logic [6:0] exp_v;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = running, 1 = draining a HALT, 2 = halted
  int  m_mode = 0;
  int  m_drained = 0;
  bit  m_halted = 1'b0;
  bit  m_ack = 1'b0;

`ifdef CPU_PIPE_CTRL_PERF_EN
  logic [CW-1:0] perf_lu, perf_flush, perf_freeze;
  logic [CW-1:0] m_lu_cnt = '0, m_flush_cnt = '0, m_freeze_cnt = '0;
`endif

  always #5 clk = ~clk;

  assign obs = {f_stall, d_stall, d_bubble, e_bubble, freeze, halted, int_ack};

  cpu_pipe_ctrl dut (
    .CLK_I         (clk),
    .RST_N_I       (rst_n),
    .D_VALID_I     (d_valid),
    .D_SRC_A_I     (d_src_a),
    .D_SRC_A_USE_I (d_use_a),
    .D_SRC_B_I     (d_src_b),
    .D_SRC_B_USE_I (d_use_b),
    .D_HALT_I      (d_halt),
    .E_VALID_I     (e_valid),
    .E_DST_I       (e_dst),
    .E_DSTR_CS_M_I (e_load),
    .M_VALID_I     (m_valid),
    .M_DST_I       (m_dst),
    .M_DSTR_CS_M_I (m_load),
    .E_REDIRECT_I  (redir),
    .MEM_READY_I   (mem_ready),
    .INT_REQ_I     (int_req),
    .F_STALL_O     (f_stall),
    .D_STALL_O     (d_stall),
    .D_BUBBLE_O    (d_bubble),
    .E_BUBBLE_O    (e_bubble),
    .PIPE_FREEZE_O (freeze),
    .HALTED_O      (halted),
    .INT_ACK_O     (int_ack)
`ifdef CPU_PIPE_CTRL_PERF_EN
    , .PERF_LU_CNT_O     (perf_lu)
    , .PERF_FLUSH_CNT_O  (perf_flush)
    , .PERF_FREEZE_CNT_O (perf_freeze)
`endif
  );

  function automatic bit ref_lu();
    bit reads_e, reads_m;
    reads_e = (d_use_a && d_src_a == e_dst) || (d_use_b && d_src_b == e_dst);
    reads_m = (d_use_a && d_src_a == m_dst) || (d_use_b && d_src_b == m_dst);
    return d_valid && ((e_valid && e_load && reads_e) || (m_valid && m_load && reads_m));
  endfunction

  // {F_STALL, D_STALL, D_BUBBLE, E_BUBBLE, FREEZE} from the priority rules
  function automatic logic [4:0] ref_comb();
    if (m_mode == 2) return 5'b10100;
    if (!mem_ready)  return (m_mode == 0) ? 5'b11001 : 5'b10101;
    if (redir)       return 5'b00110;
    if (m_mode == 1) return 5'b10100;
    if (ref_lu())    return 5'b11010;
    if (d_valid && d_halt) return 5'b10100;
    return 5'b00000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int old_mode;
    bit wake;
    if (!rst_n) begin
      m_mode = 0; m_drained = 0; m_halted = 0; m_ack = 0;
`ifdef CPU_PIPE_CTRL_PERF_EN
      m_lu_cnt = '0; m_flush_cnt = '0; m_freeze_cnt = '0;
`endif
    end else begin
      old_mode = m_mode;
      wake = 1'b0;
`ifdef CPU_PIPE_CTRL_PERF_EN
      if (old_mode == 0 && mem_ready && !redir && ref_lu() && m_lu_cnt != {CW{1'b1}}) m_lu_cnt++;
      if (redir && m_flush_cnt != {CW{1'b1}}) m_flush_cnt++;
      if (!mem_ready && m_freeze_cnt != {CW{1'b1}}) m_freeze_cnt++;
`endif
      if (old_mode == 0) begin
        if (mem_ready && !redir && !ref_lu() && d_valid && d_halt) begin
          m_mode = 1; m_drained = 0;
        end
      end else if (old_mode == 1) begin
        if (mem_ready) begin
          if (redir) m_mode = 0;
          else if (m_drained == DRAIN_CYC - 1) m_mode = 2;
          else m_drained++;
        end
      end else if (int_req) begin
        m_mode = 0;
        wake = 1'b1;
      end
      m_halted = (m_mode == 2);
      m_ack = wake;
    end
  end

  task automatic set_idle();
    d_valid = 0; d_use_a = 0; d_use_b = 0; d_halt = 0;
    d_src_a = 0; d_src_b = 0; e_dst = 0; m_dst = 0;
    e_valid = 0; e_load = 0; m_valid = 0; m_load = 0;
    redir = 0; mem_ready = 1; int_req = 0;
  endtask

  task automatic test_reset();
    set_idle();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL reset_idle: got %b expected %b", obs, 7'b0000000); end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1100100) begin errors++; $display("[TB] FAIL reset_run_freeze: got %b expected %b", obs, 7'b1100100); end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL reset_release: got %b expected %b", obs, 7'b0000000); end
  endtask

  task automatic test_load_use();
    @(negedge clk); set_idle();
    e_valid = 1; e_load = 1; e_dst = 3'd2; d_valid = 1; d_src_a = 3'd2; d_use_a = 1;
    #1; checks++;
    if (obs !== 7'b1101000) begin errors++; $display("[TB] FAIL lu_load_in_e: got %b expected %b", obs, 7'b1101000); end
    @(negedge clk);
    e_valid = 0; e_load = 0; m_valid = 1; m_load = 1; m_dst = 3'd2;
    #1; checks++;
    if (obs !== 7'b1101000) begin errors++; $display("[TB] FAIL lu_load_in_m: got %b expected %b", obs, 7'b1101000); end
    @(negedge clk);
    m_valid = 0; m_load = 0;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL lu_load_in_w: got %b expected %b", obs, 7'b0000000); end
    @(negedge clk); set_idle();
    m_valid = 1; m_load = 1; m_dst = 3'd5; d_valid = 1; d_src_b = 3'd5; d_use_b = 1; d_src_a = 3'd1; d_use_a = 1;
    #1; checks++;
    if (obs !== 7'b1101000) begin errors++; $display("[TB] FAIL lu_src_b: got %b expected %b", obs, 7'b1101000); end
    @(negedge clk);
    d_use_b = 0;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL lu_src_b_unused: got %b expected %b", obs, 7'b0000000); end
  endtask

  task automatic test_no_hazard();
    @(negedge clk); set_idle();
    e_valid = 1; e_load = 0; e_dst = 3'd2; d_valid = 1; d_src_a = 3'd2; d_use_a = 1;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL alu_no_stall: got %b expected %b", obs, 7'b0000000); end
    @(negedge clk);
    e_load = 1; e_dst = 3'd3;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL other_reg_no_stall: got %b expected %b", obs, 7'b0000000); end
    @(negedge clk);
    e_dst = 3'd2; d_valid = 0;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL d_invalid_no_stall: got %b expected %b", obs, 7'b0000000); end
  endtask

  task automatic test_redirect();
    @(negedge clk); set_idle();
    e_valid = 1; e_load = 1; e_dst = 3'd4; d_valid = 1; d_src_a = 3'd4; d_use_a = 1; redir = 1;
    #1; checks++;
    if (obs !== 7'b0011000) begin errors++; $display("[TB] FAIL redirect_over_lu: got %b expected %b", obs, 7'b0011000); end
    @(negedge clk);
    mem_ready = 0;
    #1; checks++;
    if (obs !== 7'b1100100) begin errors++; $display("[TB] FAIL freeze_over_redirect: got %b expected %b", obs, 7'b1100100); end
    @(negedge clk); set_idle();
    d_valid = 1; d_halt = 1; redir = 1;
    #1; checks++;
    if (obs !== 7'b0011000) begin errors++; $display("[TB] FAIL redirect_over_halt: got %b expected %b", obs, 7'b0011000); end
    @(negedge clk); set_idle();
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL no_drain_after_redirect: got %b expected %b", obs, 7'b0000000); end
  endtask

  task automatic test_halt_drain();
    @(negedge clk); set_idle();
    d_valid = 1; d_halt = 1;
    #1; checks++;
    if (obs !== 7'b1010000) begin errors++; $display("[TB] FAIL halt_in_d: got %b expected %b", obs, 7'b1010000); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); set_idle();
      #1; checks++;
      if (obs !== 7'b1010000) begin errors++; $display("[TB] FAIL drain_cycle%0d: got %b expected %b", i, obs, 7'b1010000); end
    end
    @(negedge clk);
    #1; checks++;
    if (obs !== 7'b1010010) begin errors++; $display("[TB] FAIL halted_cycle4: got %b expected %b", obs, 7'b1010010); end
  endtask

  task automatic test_interrupt_wake();
    @(negedge clk); set_idle();
    #1; checks++;
    if (obs !== 7'b1010010) begin errors++; $display("[TB] FAIL halted_holds: got %b expected %b", obs, 7'b1010010); end
    @(negedge clk);
    int_req = 1;
    #1; checks++;
    if (obs !== 7'b1010010) begin errors++; $display("[TB] FAIL int_req_cycle: got %b expected %b", obs, 7'b1010010); end
    @(negedge clk);
    #1; checks++;
    if (obs !== 7'b0000001) begin errors++; $display("[TB] FAIL int_ack_pulse: got %b expected %b", obs, 7'b0000001); end
    @(negedge clk);
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL int_ack_one_cycle: got %b expected %b", obs, 7'b0000000); end
    @(negedge clk); set_idle();
    e_valid = 1; e_load = 1; e_dst = 3'd6; d_valid = 1; d_src_b = 3'd6; d_use_b = 1;
    #1; checks++;
    if (obs !== 7'b1101000) begin errors++; $display("[TB] FAIL run_after_wake: got %b expected %b", obs, 7'b1101000); end
  endtask

  task automatic test_halt_mem_wait();
    logic [6:0] seq_exp [0:8];
    seq_exp = '{7'b1010000, 7'b1010000, 7'b1010100, 7'b1010100, 7'b1010000,
                7'b1010000, 7'b1010010, 7'b1010010, 7'b0000001};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); set_idle();
      if (i == 0) begin d_valid = 1; d_halt = 1; end
      if (i == 1) int_req = 1;
      if (i == 2 || i == 3) mem_ready = 0;
      if (i == 7) int_req = 1;
      #1; checks++;
      if (obs !== seq_exp[i]) begin errors++; $display("[TB] FAIL drain_wait_step%0d: got %b expected %b", i, obs, seq_exp[i]); end
    end
  endtask

  task automatic test_drain_redirect();
    @(negedge clk); set_idle();
    d_valid = 1; d_halt = 1;
    @(negedge clk); set_idle();
    #1; checks++;
    if (obs !== 7'b1010000) begin errors++; $display("[TB] FAIL cancel_drain_pre: got %b expected %b", obs, 7'b1010000); end
    @(negedge clk);
    redir = 1;
    #1; checks++;
    if (obs !== 7'b0011000) begin errors++; $display("[TB] FAIL cancel_drain_redirect: got %b expected %b", obs, 7'b0011000); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_idle();
      #1; checks++;
      if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL cancel_drain_run%0d: got %b expected %b", i, obs, 7'b0000000); end
    end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); set_idle();
    d_valid = 1; d_halt = 1;
    @(negedge clk); set_idle();
    #1; checks++;
    if (obs !== 7'b1010000) begin errors++; $display("[TB] FAIL mid_drain_pre: got %b expected %b", obs, 7'b1010000); end
    #2 rst_n = 1'b0;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL reset_in_drain: got %b expected %b", obs, 7'b0000000); end
    @(negedge clk); rst_n = 1'b1;
    d_valid = 1; d_halt = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_idle();
    end
    #1; checks++;
    if (obs !== 7'b1010010) begin errors++; $display("[TB] FAIL halted_pre_reset: got %b expected %b", obs, 7'b1010010); end
    #2 rst_n = 1'b0;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL reset_in_halted: got %b expected %b", obs, 7'b0000000); end
    @(negedge clk); rst_n = 1'b1;
    #1; checks++;
    if (obs !== 7'b0000000) begin errors++; $display("[TB] FAIL run_after_reset: got %b expected %b", obs, 7'b0000000); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      d_valid   = ($urandom_range(0, 3) != 0);
      d_src_a   = 3'($urandom_range(0, 3));
      d_use_a   = ($urandom_range(0, 2) != 0);
      d_src_b   = 3'($urandom_range(0, 3));
      d_use_b   = ($urandom_range(0, 2) != 0);
      d_halt    = ($urandom_range(0, 7) == 0);
      e_valid   = ($urandom_range(0, 1) != 0);
      e_dst     = 3'($urandom_range(0, 3));
      e_load    = ($urandom_range(0, 2) == 0);
      m_valid   = ($urandom_range(0, 1) != 0);
      m_dst     = 3'($urandom_range(0, 3));
      m_load    = ($urandom_range(0, 2) == 0);
      redir     = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 4) != 0);
      int_req   = ($urandom_range(0, 3) == 0);
      #1;
      exp_v = {ref_comb(), m_halted, m_ack};
      checks++;
      if (obs !== exp_v) begin errors++; $display("[TB] FAIL random_cycle%0d: got %b expected %b", i, obs, exp_v); end
    end
`ifdef CPU_PIPE_CTRL_PERF_EN
    checks++;
    if ({perf_lu, perf_flush, perf_freeze} !== {m_lu_cnt, m_flush_cnt, m_freeze_cnt}) begin
      errors++;
      $display("[TB] FAIL random_perf: got %h/%h/%h expected %h/%h/%h", perf_lu, perf_flush, perf_freeze, m_lu_cnt, m_flush_cnt, m_freeze_cnt);
    end
`endif
    @(negedge clk); set_idle();
  endtask

`ifdef CPU_PIPE_CTRL_PERF_EN
  task automatic test_perf();
    @(negedge clk); set_idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); set_idle();
      d_valid = 1; d_src_a = 3'd1; d_use_a = 1; e_valid = 1; e_load = 1; e_dst = 3'd1;
      if (i >= 5) redir = 1;
    end
    @(negedge clk); set_idle();
    #1; checks++;
    if (perf_lu !== 16'd5 || perf_flush !== 16'd2 || perf_freeze !== 16'd0) begin
      errors++;
      $display("[TB] FAIL perf_counts: got %0d/%0d/%0d expected 5/2/0", perf_lu, perf_flush, perf_freeze);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting cpu_pipe_ctrl bench");
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_halt_drain();
    test_interrupt_wake();
    test_halt_mem_wait();
    test_drain_redirect();
    test_reset_mid_drain();
    test_random();
`ifdef CPU_PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
